// File: rtl/regfile_read_scheduler.sv
// Operand read scheduler for a 2-read-port register file with fixed 2-cycle latency.
// Arbitrates decoder/debug requests, tracks reads in flight and buffers results under credit control.
module regfile_read_scheduler #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [TAG_W-1:0]  dec_tag,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    input  logic [DATA_W-1:0] rf_rs1_data,
    input  logic [DATA_W-1:0] rf_rs2_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_rs1_data,
    output logic [DATA_W-1:0] op_rs2_data,
    output logic [TAG_W-1:0]  op_tag,
    output logic              op_src,
    output logic              busy
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OUT_W = $clog2(BUF_DEPTH + 3);
    localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {
        GRANT_DEC = 1'b0,
        GRANT_DBG = 1'b1
    } grant_e;

    grant_e             r_lastGrant;
    logic               r_s1Valid, r_s2Valid;
    logic               r_s1Src, r_s2Src;
    logic [TAG_W-1:0]   r_s1Tag, r_s2Tag;
    logic               r_s1Zero1, r_s1Zero2, r_s2Zero1, r_s2Zero2;

    logic [DATA_W-1:0]  r_memD1  [BUF_DEPTH];
    logic [DATA_W-1:0]  r_memD2  [BUF_DEPTH];
    logic [TAG_W-1:0]   r_memTag [BUF_DEPTH];
    logic               r_memSrc [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr, r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    logic [OUT_W-1:0]   w_outstanding;
    logic               w_issueOk, w_grantDec, w_grantDbg, w_issue;
    logic               w_push, w_pop;
    logic [PTR_W-1:0]   w_headIdx;

    // Credits cover both reads in flight and buffered entries, so a full FIFO can always absorb returns.
    assign w_outstanding = OUT_W'(r_s1Valid) + OUT_W'(r_s2Valid) + OUT_W'(r_count);
    assign w_issueOk     = !rst && (w_outstanding < OUT_LIMIT);

    always_comb begin
        w_grantDec = 1'b0;
        w_grantDbg = 1'b0;
        if (w_issueOk) begin
            if (dec_valid && (!dbg_valid || r_lastGrant == GRANT_DBG)) begin
                w_grantDec = 1'b1;
            end else if (dbg_valid) begin
                w_grantDbg = 1'b1;
            end
        end
    end

    assign w_issue   = w_grantDec | w_grantDbg;
    assign dec_ready = w_grantDec;
    assign dbg_ready = w_grantDbg;
    assign rf_rs1    = w_grantDec ? dec_rs1 : (w_grantDbg ? dbg_addr : '0);
    assign rf_rs2    = w_grantDec ? dec_rs2 : '0;

    assign op_valid  = (r_count != '0);
    assign w_push    = r_s2Valid;
    assign w_pop     = op_valid && op_ready;
    assign busy      = r_s1Valid | r_s2Valid | op_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid   <= 1'b0;
            r_s2Valid   <= 1'b0;
            r_lastGrant <= GRANT_DBG;
        end else begin
            r_s1Valid <= w_issue;
            r_s2Valid <= r_s1Valid;
            if (w_grantDec) begin
                r_lastGrant <= GRANT_DEC;
            end else if (w_grantDbg) begin
                r_lastGrant <= GRANT_DBG;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_s1Src   <= w_grantDbg;
        r_s1Tag   <= w_grantDec ? dec_tag : '0;
        r_s1Zero1 <= (rf_rs1 == '0);
        r_s1Zero2 <= (rf_rs2 == '0);
        r_s2Src   <= r_s1Src;
        r_s2Tag   <= r_s1Tag;
        r_s2Zero1 <= r_s1Zero1;
        r_s2Zero2 <= r_s1Zero2;
    end

    // Register x0 reads as zero regardless of what the array returns.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memD1[r_wrPtr]  <= r_s2Zero1 ? '0 : rf_rs1_data;
            r_memD2[r_wrPtr]  <= r_s2Zero2 ? '0 : rf_rs2_data;
            r_memTag[r_wrPtr] <= r_s2Tag;
            r_memSrc[r_wrPtr] <= r_s2Src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // When empty, show the most recently popped slot so the outputs hold their last values.
    always_comb begin
        w_headIdx = r_rdPtr;
        if (r_count == '0) begin
            w_headIdx = (r_rdPtr == '0) ? PTR_LAST : r_rdPtr - PTR_W'(1);
        end
    end

    assign op_rs1_data = r_memD1[w_headIdx];
    assign op_rs2_data = r_memD2[w_headIdx];
    assign op_tag      = r_memTag[w_headIdx];
    assign op_src      = r_memSrc[w_headIdx];

endmodule

// File: tb/tb_regfile_read_scheduler.sv
// Self-checking bench for regfile_read_scheduler: register file model, queue-based reference model,
// directed scenarios with literal expectations and a long randomized phase.
module tb_regfile_read_scheduler;

    localparam int BUF_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1, dec_rs2;
    logic [3:0]  dec_tag;
    logic        dbg_valid, dbg_ready;
    logic [4:0]  dbg_addr;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        op_valid, op_ready;
    logic [31:0] op_rs1_data, op_rs2_data;
    logic [3:0]  op_tag;
    logic        op_src;
    logic        busy;

    regfile_read_scheduler #(
        .ADDR_W(5), .DATA_W(32), .TAG_W(4), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_tag(dec_tag),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .op_tag(op_tag), .op_src(op_src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: address presented in cycle T, data visible throughout T+2, no reset.
    logic [31:0] mem [32];
    logic [4:0]  a1d1 = '0, a1d2 = '0, a2d1 = '0, a2d2 = '0;
    always @(posedge clk) begin
        a1d1 <= rf_rs1;
        a1d2 <= a1d1;
        a2d1 <= rf_rs2;
        a2d2 <= a2d1;
    end
    assign rf_rs1_data = mem[a1d2];
    assign rf_rs2_data = mem[a2d2];

    typedef struct {
        logic        src;
        logic [3:0]  tag;
        logic [31:0] d1;
        logic [31:0] d2;
    } bundle_t;

    typedef struct {
        logic       src;
        logic [3:0] tag;
        logic [4:0] a1;
        logic [4:0] a2;
        int         age;
    } req_t;

    bundle_t fifoQ[$];
    req_t    flightQ[$];
    logic    lastDbg = 1'b1;
    bit      modelValid = 1'b0;
    int      checks = 0;
    int      errors = 0;

    function automatic logic [31:0] regValue(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Registered outputs against the model's view of the current cycle.
    task automatic checkOutput();
        if (modelValid) begin
            checkVal("op_valid", op_valid, 64'(fifoQ.size() > 0));
            checkVal("busy", busy, 64'((fifoQ.size() + flightQ.size()) > 0));
            checkVal("occupancy_bound", 64'(dut.r_count <= BUF_DEPTH), 64'd1);
            if (fifoQ.size() > 0) begin
                checkVal("op_rs1_data", op_rs1_data, fifoQ[0].d1);
                checkVal("op_rs2_data", op_rs2_data, fifoQ[0].d2);
                checkVal("op_tag", op_tag, fifoQ[0].tag);
                checkVal("op_src", op_src, fifoQ[0].src);
            end
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [3:0] tg, input logic gv, input logic [4:0] ga,
                                 input logic ordy, input logic r);
        dec_valid = dv;
        dec_rs1   = r1;
        dec_rs2   = r2;
        dec_tag   = tg;
        dbg_valid = gv;
        dbg_addr  = ga;
        op_ready  = ordy;
        rst       = r;
    endtask

    // Combinational grant outputs, then advance the model across the coming clock edge.
    task automatic checkCombAndAdvance();
        int      outst;
        logic    gDec, gDbg;
        req_t    rq;
        bundle_t bd;
        outst = fifoQ.size() + flightQ.size();
        gDec = 1'b0;
        gDbg = 1'b0;
        if (!rst && outst < BUF_DEPTH) begin
            if (dec_valid && (!dbg_valid || lastDbg)) gDec = 1'b1;
            else if (dbg_valid) gDbg = 1'b1;
        end
        checkVal("dec_ready", dec_ready, gDec);
        checkVal("dbg_ready", dbg_ready, gDbg);
        checkVal("rf_rs1", rf_rs1, gDec ? dec_rs1 : (gDbg ? dbg_addr : 5'd0));
        checkVal("rf_rs2", rf_rs2, gDec ? dec_rs2 : 5'd0);
        if (rst) begin
            fifoQ.delete();
            flightQ.delete();
            lastDbg    = 1'b1;
            modelValid = 1'b1;
        end else begin
            if (fifoQ.size() > 0 && op_ready) fifoQ.delete(0);
            for (int i = 0; i < flightQ.size(); i++) flightQ[i].age++;
            while (flightQ.size() > 0 && flightQ[0].age >= 2) begin
                bd.src = flightQ[0].src;
                bd.tag = flightQ[0].tag;
                bd.d1  = regValue(flightQ[0].a1);
                bd.d2  = regValue(flightQ[0].a2);
                fifoQ.push_back(bd);
                flightQ.delete(0);
            end
            if (gDec || gDbg) begin
                rq.src = gDbg;
                rq.tag = gDec ? dec_tag : 4'd0;
                rq.a1  = gDec ? dec_rs1 : dbg_addr;
                rq.a2  = gDec ? dec_rs2 : 5'd0;
                rq.age = 0;
                flightQ.push_back(rq);
                lastDbg = gDbg;
            end
        end
    endtask

    task automatic cycle(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [3:0] tg, input logic gv, input logic [4:0] ga,
                         input logic ordy, input logic r);
        @(posedge clk);
        #1;
        checkOutput();
        applyStimulus(dv, r1, r2, tg, gv, ga, ordy, r);
        #1;
        checkCombAndAdvance();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, ordy, 1'b0);
    endtask

    int grants;
    logic [4:0] ra, rb;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'hDEADBEEF;
        mem[3] = 32'h33;
        mem[5] = 32'h55;
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1);

        cycle(1'b0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd3, 5'd5, 4'd7, 1'b1, 5'd3, 1'b1, 1'b1);
        checkVal("reset_dec_ready", dec_ready, 1'b0);

        // Single decoder read: first grant after reset goes to the decoder, bundle appears in T+3.
        cycle(1'b1, 5'd3, 5'd5, 4'd7, 1'b0, 5'd0, 1'b1, 1'b0);
        checkVal("after_reset_op_valid", op_valid, 1'b0);
        checkVal("after_reset_busy", busy, 1'b0);
        checkVal("single_grant", dec_ready, 1'b1);
        idle(1'b1);
        checkVal("single_t1_valid", op_valid, 1'b0);
        idle(1'b1);
        checkVal("single_t2_valid", op_valid, 1'b0);
        idle(1'b1);
        checkVal("single_t3_valid", op_valid, 1'b1);
        checkVal("single_rs1", op_rs1_data, 32'h33);
        checkVal("single_rs2", op_rs2_data, 32'h55);
        checkVal("single_tag", op_tag, 4'd7);
        checkVal("single_src", op_src, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // x0 forcing on both the decoder and the debug path.
        cycle(1'b1, 5'd0, 5'd0, 4'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        checkVal("x0_dbg_grant", dbg_ready, 1'b1);
        idle(1'b1);
        idle(1'b1);
        checkVal("x0_dec_valid", op_valid, 1'b1);
        checkVal("x0_dec_rs1", op_rs1_data, 32'd0);
        checkVal("x0_dec_rs2", op_rs2_data, 32'd0);
        idle(1'b1);
        checkVal("x0_dbg_valid", op_valid, 1'b1);
        checkVal("x0_dbg_rs1", op_rs1_data, 32'd0);
        checkVal("x0_dbg_rs2", op_rs2_data, 32'd0);
        checkVal("x0_dbg_src", op_src, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Round-robin with both requesters always valid.
        for (int i = 0; i < 12; i++) begin
            ra = 5'($urandom_range(1, 31));
            rb = 5'($urandom_range(1, 31));
            cycle(1'b1, ra, rb, 4'(i), 1'b1, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
            checkVal("rr_dec_ready", dec_ready, 64'(i % 2 == 0));
            checkVal("rr_dbg_ready", dbg_ready, 64'(i % 2 == 1));
            if (i >= 3) begin
                checkVal("rr_op_valid", op_valid, 1'b1);
                checkVal("rr_op_src", op_src, 64'((i - 3) % 2));
            end
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Backpressure: credits run out after BUF_DEPTH grants; a pop does not return a credit that cycle.
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 4'(i),
                  1'b0, 5'd0, 1'b0, 1'b0);
            grants += int'(dec_ready);
        end
        checkVal("bp_grants", grants, 4);
        cycle(1'b1, 5'd1, 5'd2, 4'd8, 1'b0, 5'd0, 1'b1, 1'b0);
        checkVal("bp_no_bypass", dec_ready, 1'b0);
        checkVal("bp_head_tag", op_tag, 4'd0);
        cycle(1'b1, 5'd1, 5'd2, 4'd8, 1'b0, 5'd0, 1'b1, 1'b0);
        checkVal("bp_credit_back", dec_ready, 1'b1);
        checkVal("bp_next_tag", op_tag, 4'd1);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Three buffered, one in flight, then simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 4'(i),
                  1'b0, 5'd0, 1'b0, 1'b0);
        end
        idle(1'b0);
        idle(1'b1);
        checkVal("full_pre_occ", dut.r_count, 3);
        checkVal("full_tag0", op_tag, 4'd0);
        idle(1'b1);
        checkVal("full_simul_occ", dut.r_count, 3);
        checkVal("full_tag1", op_tag, 4'd1);
        idle(1'b1);
        checkVal("full_tag2", op_tag, 4'd2);
        idle(1'b1);
        checkVal("full_tag3", op_tag, 4'd3);
        checkVal("full_last_valid", op_valid, 1'b1);
        idle(1'b1);
        checkVal("full_drained", op_valid, 1'b0);

        // Reset with two reads in flight and one buffered.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 4'(i + 4),
                  1'b0, 5'd0, 1'b0, 1'b0);
        end
        cycle(1'b1, 5'd4, 5'd6, 4'd9, 1'b1, 5'd7, 1'b1, 1'b1);
        checkVal("rst_mid_dec_ready", dec_ready, 1'b0);
        cycle(1'b1, 5'd4, 5'd6, 4'd9, 1'b1, 5'd7, 1'b1, 1'b0);
        checkVal("rst_mid_op_valid", op_valid, 1'b0);
        checkVal("rst_mid_busy", busy, 1'b0);
        checkVal("rst_mid_first_dec", dec_ready, 1'b1);
        checkVal("rst_mid_first_dbg", dbg_ready, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Randomized traffic with phases of heavy and light backpressure and rare resets.
        for (int n = 0; n < 3000; n++) begin
            logic ordy;
            ordy = ((n / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                  ordy, 1'($urandom_range(0, 249) == 0));
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        checkVal("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_read_scheduler.md
Name: regfile_read_scheduler

Overview:
- Sequences all operand reads into the 32x32 two-read-port register file.
- The register file has a fixed 2-cycle read latency, no stall input and no reset.
- Arbitrates between the instruction decoder and a debug read port, then tracks reads in flight.
- Buffers returned operands in a credit-limited FIFO so that downstream backpressure never loses data.
- Presents tagged operand bundles on a valid/ready interface.

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- TAG_W, 4: width of the decoder transaction tag.
- BUF_DEPTH, 4: operand buffer entries; also the maximum number of outstanding reads. Legal range is 3 to 8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decoder request valid
- dec_ready  out  1  decoder request accepted this cycle
- dec_rs1  in  ADDR_W  decoder source register 1
- dec_rs2  in  ADDR_W  decoder source register 2
- dec_tag  in  TAG_W  decoder transaction tag
- dbg_valid  in  1  debug request valid
- dbg_ready  out  1  debug request accepted this cycle
- dbg_addr  in  ADDR_W  debug register address
- rf_rs1  out  ADDR_W  register file read address 1
- rf_rs2  out  ADDR_W  register file read address 2
- rf_rs1_data  in  DATA_W  register file read data 1
- rf_rs2_data  in  DATA_W  register file read data 2
- op_valid  out  1  operand bundle valid
- op_ready  in  1  consumer accepts the bundle
- op_rs1_data  out  DATA_W  operand 1
- op_rs2_data  out  DATA_W  operand 2
- op_tag  out  TAG_W  tag of the bundle
- op_src  out  1  0 = decoder, 1 = debug
- busy  out  1  any read in flight or buffered

Behaviour:
- **Clock and reset:** one clock, clk. Reset is rst: synchronous, active-high.
- **Reset state:**
  - Clears both pipeline valid bits, the FIFO pointers and the occupancy count.
  - Sets last_grant to debug.
  - While rst is high: dec_ready=0, dbg_ready=0, rf_rs1=0, rf_rs2=0.
  - Cycle after reset: op_valid=0, busy=0.
- **Outstanding count:**
  - outstanding = in-flight reads (0..2) + FIFO occupancy.
  - Issue is allowed only when outstanding < BUF_DEPTH.
  - A pop in the same cycle does not create a credit; there is no bypass.
- **Arbitration** (combinational, in the issue cycle T):
  - Only one requester wins, and only if issue is allowed.
  - Only one valid requester: it wins.
  - Both valid: round-robin; the winner is the one not granted last. After reset the decoder wins first.
  - last_grant updates only on a grant.
  - Winner's ready = 1 and loser's ready = 0; both are 0 when issue is blocked.
  - A ready may depend on the other port's valid and on its own valid.
- **Register file drive in cycle T:**
  - Decoder grant: rf_rs1=dec_rs1, rf_rs2=dec_rs2.
  - Debug grant: rf_rs1=dbg_addr, rf_rs2=0.
  - No grant: both 0.
- **Read pipeline:**
  - Two-stage shift of {valid, src, tag, zero1, zero2}.
  - zeroN = 1 when the issued address is 0. Debug issues set zero2=1 and tag=0.
  - Stage 2 is valid during T+2. rf_rsN_data is sampled then and pushed into the FIFO at the end of T+2.
  - Pushed data is forced to 0 where zeroN=1 (x0 always reads zero, whatever the register file holds).
- **Latency:** op_valid rises earliest in T+3. Throughput is one bundle per cycle when op_ready is held high and BUF_DEPTH>=4.
- **FIFO:**
  - Strictly in-order.
  - Push and pop in the same cycle are both honoured, including when full or empty.
  - op_* outputs are driven from the head entry, which is registered storage.
  - Pop occurs when op_valid && op_ready.
  - When op_valid=0, op_* data and tag hold their last values. Consumers must not use them.
- **Overflow:** cannot occur by construction. The bench asserts occupancy never exceeds BUF_DEPTH.
- **busy:** 1 when any pipeline valid bit is set or occupancy > 0.
- **Reset mid-operation:**
  - In-flight and buffered entries are discarded.
  - Data the register file returns after reset is ignored, because the pipeline valid bits are cleared.

Test Plan:
- **Single decoder read:** register file preloaded mem[3]=0x33, mem[5]=0x55. Decoder request rs1=3, rs2=5, tag=7 granted in cycle T -> op_valid=1 in T+3 with op_rs1_data=0x33, op_rs2_data=0x55, op_tag=7, op_src=0.
- **x0 forcing:** mem[0]=0xDEADBEEF, decoder request rs1=0, rs2=0 -> bundle has both operands =0. Debug read of addr 0 -> op_rs1_data=0, op_rs2_data=0, op_src=1.
- **Round-robin:** dec_valid=dbg_valid=1 continuously, op_ready=1 -> grant order dec, dbg, dec, dbg...; after the first 3 cycles, op_valid stays 1 every cycle and op_src alternates 0,1,0,1.
- **Backpressure:** op_ready=0 with the decoder streaming -> exactly 4 grants, then dec_ready=0. Raise op_ready -> 4 bundles pop in issue order, and dec_ready returns to 1 only once outstanding < 4.
- **Full plus simultaneous push/pop:** FIFO holding 3 with 1 in flight, op_ready=1 -> occupancy stays 3 through the simultaneous push/pop cycle, no bundle lost or duplicated, and tags stay sequential.
- **Reset mid-flight:** 2 reads in flight and 1 buffered, rst=1 for one cycle -> next cycle op_valid=0 and busy=0, no stale bundle ever emerges, and the first post-reset grant goes to the decoder.
